retire_ctrl: RTL and testbench
==============================

// Module: retire_ctrl
// PURPOSE
// - Sequences in-order retirement at the ROB head: selects how many of the N oldest entries retire each cycle.
// - Gates stores through a one-per-cycle store-queue commit handshake.
// - Runs the halt drain FSM and keeps the retired-instruction counter.
// - Sits between ROB, freddylist (complete list / free regs) and store queue; drives num_retiring / phys_regs_retiring.
// PARAMETERS
// - CNT_W            64    width of retired_count
// - WATCHDOG_CYCLES  1024  stall cycles before deadlock flag (RETIRE_WATCHDOG_EN only)
// - `N, `NUM_SCALAR_BITS, `PHYS_REG_SZ_R10K come from sys_defs.svh
// PORTS
// - clock                  in   1                        system clock, all state on posedge
// - reset                  in   1                        synchronous, active-low
// - rob_outputs            in   ROB_PACKET [`N-1:0]      head entries, [0] oldest; uses T_new, T_old, has_dest, is_store, halt
// - rob_outputs_valid      in   `NUM_SCALAR_BITS         count of valid head entries (0..N)
// - complete_list_exposed  in   `PHYS_REG_SZ_R10K        1 = phys reg T_new completed
// - sq_retire_req          out  1                        a complete store is at the retire point this cycle
// - sq_retire_ack          in   1                        store queue commits that store this cycle (same-cycle)
// - sq_empty               in   1                        store queue has no committed-unwritten stores
// - num_retiring           out  `NUM_SCALAR_BITS         entries popped from ROB this cycle
// - phys_regs_retiring     out  PHYS_REG_IDX [`N-1:0]    regs freed: T_old if has_dest else T_new; 0 for i>=num_retiring
// - halt_retired           out  1                        1 only in state HALTED
// - retired_count          out  CNT_W                    total instructions retired since reset
// - retire_deadlock        out  1                        watchdog flag (tied 0 without RETIRE_WATCHDOG_EN)
// BEHAVIOUR
// - FSM states:
//   - RUN: normal retirement.
//   - DRAIN: a halt has retired; retirement is blocked.
//   - HALTED: terminal state until reset.
// - Scan, combinational in RUN only, slot i=0..N-1 oldest-first. Slot i retires iff all of:
//   - i < rob_outputs_valid
//   - complete_list_exposed[rob_outputs[i].T_new]
//   - all slots < i retire
//   - store rule below holds
// - Store rule:
//   - Only the first store in scan order may retire, and only when sq_retire_ack=1.
//   - sq_retire_req=1 when the scan reaches a complete store.
//   - Scan stops after a store slot (retired or not); a second store in the group never retires the same cycle.
// - Halt rule:
//   - A complete halt entry retires and ends the scan (younger slots are not retired).
//   - Next state is DRAIN.
// - DRAIN:
//   - num_retiring=0, sq_retire_req=0.
//   - Moves to HALTED on the first cycle sq_empty=1 (earliest: the cycle after entering DRAIN).
// - HALTED: num_retiring=0; halt_retired=1; stays until reset.
// - num_retiring = count of retiring slots, always <= rob_outputs_valid; never counts an incomplete entry.
// - phys_regs_retiring[i] is never 0 for i<num_retiring; reg 0 is excluded as a source of freed regs.
// - retired_count += num_retiring at each posedge (in RUN); wraps modulo 2^CNT_W.
// - Outputs num_retiring, phys_regs_retiring, sq_retire_req are combinational from current state and inputs (0-cycle latency).
// - Reset (reset=0 at posedge), including mid-DRAIN or mid-handshake:
//   - state=RUN, retired_count=0, watchdog counter=0.
//   - During the reset cycle: num_retiring=0, sq_retire_req=0, halt_retired=0, retire_deadlock=0.
// - Boundaries:
//   - rob_outputs_valid=0 -> num_retiring=0.
//   - sq_retire_ack with no request is ignored.
//   - Halt and store in the same group -> the older one decides the stop.
// CONFIGURATION
// - RETIRE_WATCHDOG_EN defined:
//   - Counter increments each RUN cycle with rob_outputs_valid>0 and num_retiring=0.
//   - Counter clears on any retirement.
//   - retire_deadlock=1 (sticky until reset) once the counter reaches WATCHDOG_CYCLES.
// - RETIRE_WATCHDOG_EN undefined: no counter logic; retire_deadlock tied 0.
// TESTING
// - Valid=N=4, all complete, no stores/halts -> num_retiring=4, retired_count +4, regs = T_old/T_new by has_dest.
// - Valid=4, slot 2 incomplete -> num_retiring=2; slot 3 not retired even if complete.
// - Stores in slots 1 and 2, all complete, ack=1 -> req=1, num_retiring=2; next cycle slot 0 store retires alone.
// - Store in slot 0, ack=0 for 3 cycles then 1 -> num_retiring=0,0,0,1.
// - Halt in slot 1, sq_empty=0 for 2 cycles -> num_retiring=2, DRAIN 2 cycles, then halt_retired=1; reset=0 -> RUN, count=0.
// - RETIRE_WATCHDOG_EN, WATCHDOG_CYCLES=8, head incomplete 8 cycles -> retire_deadlock=1 on the 8th posedge.

Source files
------------

// File: rtl/retire_ctrl.sv
// retire_ctrl: in-order retirement at the ROB head, one-per-cycle store commit handshake,
// halt drain FSM and retired-instruction counter. Optional RETIRE_WATCHDOG_EN adds a deadlock flag.
`ifndef N
`define N 4
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 3
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

package retire_ctrl_pkg;
   typedef logic [$clog2(`PHYS_REG_SZ_R10K)-1:0] PHYS_REG_IDX;
   typedef struct packed {
      PHYS_REG_IDX T_new;
      PHYS_REG_IDX T_old;
      logic        has_dest;
      logic        is_store;
      logic        halt;
   } ROB_PACKET;
endpackage

module retire_ctrl
   import retire_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W           = 64,
   parameter int unsigned WATCHDOG_CYCLES = 1024
) (
   input  logic                          clock,
   input  logic                          reset,
   input  ROB_PACKET [`N-1:0]            rob_outputs,
   input  logic [`NUM_SCALAR_BITS-1:0]   rob_outputs_valid,
   input  logic [`PHYS_REG_SZ_R10K-1:0]  complete_list_exposed,
   output logic                          sq_retire_req,
   input  logic                          sq_retire_ack,
   input  logic                          sq_empty,
   output logic [`NUM_SCALAR_BITS-1:0]   num_retiring,
   output PHYS_REG_IDX [`N-1:0]          phys_regs_retiring,
   output logic                          halt_retired,
   output logic [CNT_W-1:0]              retired_count,
   output logic                          retire_deadlock
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_count;
   logic              w_scan;
   logic              w_take;
   logic              w_halt_retiring;
   PHYS_REG_IDX       w_freed;

   always_comb begin
      w_state_next       = r_state;
      num_retiring       = '0;
      phys_regs_retiring = '0;
      sq_retire_req      = 1'b0;
      w_halt_retiring    = 1'b0;
      w_scan             = 1'b0;
      w_take             = 1'b0;
      w_freed            = '0;
      case (r_state)
         RUN: begin
            w_scan = reset;
            for (int unsigned i = 0; i < `N; i++) begin
               w_freed = rob_outputs[i].has_dest ? rob_outputs[i].T_old : rob_outputs[i].T_new;
               if (w_scan) begin
                  // A freed reg of 0 would alias the hardwired zero reg, so such a slot holds the scan.
                  if (i >= 32'(rob_outputs_valid) || !complete_list_exposed[rob_outputs[i].T_new]
                      || w_freed == '0) begin
                     w_scan = 1'b0;
                  end else begin
                     w_take = rob_outputs[i].is_store ? sq_retire_ack : 1'b1;
                     if (rob_outputs[i].is_store)
                        sq_retire_req = 1'b1;
                     if (w_take) begin
                        num_retiring          = `NUM_SCALAR_BITS'(i + 1);
                        phys_regs_retiring[i] = w_freed;
                        if (rob_outputs[i].halt)
                           w_halt_retiring = 1'b1;
                     end
                     if (rob_outputs[i].is_store || rob_outputs[i].halt || !w_take)
                        w_scan = 1'b0;
                  end
               end
            end
            if (w_halt_retiring)
               w_state_next = DRAIN;
         end
         DRAIN: begin
            if (sq_empty)
               w_state_next = HALTED;
         end
         default: begin
            w_state_next = HALTED;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= RUN;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == RUN)
            r_count <= r_count + CNT_W'(num_retiring);
      end
   end

   assign retired_count = r_count;
   assign halt_retired  = reset && (r_state == HALTED);

`ifdef RETIRE_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_deadlock;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wd_cnt   <= '0;
         r_deadlock <= 1'b0;
      end else if (r_state == RUN) begin
         if (num_retiring != '0) begin
            r_wd_cnt <= '0;
         end else if (rob_outputs_valid != '0 && r_wd_cnt < WD_W'(WATCHDOG_CYCLES)) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
            if (r_wd_cnt == WD_W'(WATCHDOG_CYCLES - 1))
               r_deadlock <= 1'b1;
         end
      end
   end

   assign retire_deadlock = reset && r_deadlock;
`else
   assign retire_deadlock = 1'b0;
`endif

endmodule

// File: tb/tb_retire_ctrl.sv
// Bench for retire_ctrl: vector table plus hand sequences (store handshake, halt drain, reset, watchdog).
`timescale 1ns/1ps
`ifndef N
`define N 4
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 3
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

module tb_retire_ctrl;
   import retire_ctrl_pkg::*;

   localparam int unsigned CNT_W = 64;
   localparam int unsigned WD    = 8;
`ifdef RETIRE_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic                          clock = 1'b0;
   logic                          reset = 1'b0;
   ROB_PACKET [`N-1:0]            rob_outputs = '0;
   logic [`NUM_SCALAR_BITS-1:0]   rob_outputs_valid = '0;
   logic [`PHYS_REG_SZ_R10K-1:0]  complete_list_exposed = '0;
   logic                          sq_retire_req;
   logic                          sq_retire_ack = 1'b0;
   logic                          sq_empty = 1'b1;
   logic [`NUM_SCALAR_BITS-1:0]   num_retiring;
   PHYS_REG_IDX [`N-1:0]          phys_regs_retiring;
   logic                          halt_retired;
   logic [CNT_W-1:0]              retired_count;
   logic                          retire_deadlock;

   retire_ctrl #(.CNT_W(CNT_W), .WATCHDOG_CYCLES(WD)) dut (
      .clock(clock), .reset(reset), .rob_outputs(rob_outputs),
      .rob_outputs_valid(rob_outputs_valid), .complete_list_exposed(complete_list_exposed),
      .sq_retire_req(sq_retire_req), .sq_retire_ack(sq_retire_ack), .sq_empty(sq_empty),
      .num_retiring(num_retiring), .phys_regs_retiring(phys_regs_retiring),
      .halt_retired(halt_retired), .retired_count(retired_count),
      .retire_deadlock(retire_deadlock)
   );

   always #5 clock = ~clock;

   typedef struct {
      int unsigned valid;
      logic [3:0]  comp;
      logic [3:0]  st;
      logic [3:0]  hl;
      logic [3:0]  dst;
      logic        ack;
      int unsigned exp_num;
      logic        exp_req;
   } vec_t;

   typedef struct {
      string                tag;
      int unsigned          num;
      logic                 req;
      logic                 halted;
      logic                 dead;
      PHYS_REG_IDX [`N-1:0] regs;
      logic [CNT_W-1:0]     cnt;
   } exp_t;

   vec_t             vecs[$];
   exp_t             sb[$];
   int               checks = 0;
   int               errors = 0;
   logic [CNT_W-1:0] model_cnt = '0;
   logic [3:0]       cur_dst = '0;

   function automatic vec_t mkv(int unsigned valid, logic [3:0] comp, logic [3:0] st,
                                logic [3:0] hl, logic [3:0] dst, logic ack,
                                int unsigned en, logic er);
      vec_t v;
      v.valid = valid; v.comp = comp; v.st = st; v.hl = hl; v.dst = dst; v.ack = ack;
      v.exp_num = en; v.exp_req = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Slot i holds T_new=10+i, T_old=20+i; comp bit i marks T_new complete.
   task automatic drive(input int unsigned valid, input logic [3:0] comp, input logic [3:0] st,
                        input logic [3:0] hl, input logic [3:0] dst, input logic ack, input logic sqe);
      complete_list_exposed = '0;
      for (int i = 0; i < `N; i++) begin
         rob_outputs[i].T_new    = PHYS_REG_IDX'(10 + i);
         rob_outputs[i].T_old    = PHYS_REG_IDX'(20 + i);
         rob_outputs[i].has_dest = dst[i];
         rob_outputs[i].is_store = st[i];
         rob_outputs[i].halt     = hl[i];
         if (comp[i]) complete_list_exposed[10 + i] = 1'b1;
      end
      rob_outputs_valid = `NUM_SCALAR_BITS'(valid);
      sq_retire_ack     = ack;
      sq_empty          = sqe;
      cur_dst           = dst;
   endtask

   task automatic expect_out(input string tag, input int unsigned num, input logic req,
                             input logic halted, input logic dead);
      exp_t e;
      e.tag = tag; e.num = num; e.req = req; e.halted = halted; e.dead = dead;
      e.cnt = model_cnt;
      e.regs = '0;
      for (int i = 0; i < `N; i++)
         if (i < int'(num)) e.regs[i] = cur_dst[i] ? PHYS_REG_IDX'(20 + i) : PHYS_REG_IDX'(10 + i);
      sb.push_back(e);
      model_cnt = model_cnt + CNT_W'(num);
   endtask

   task automatic compare_next();
      exp_t e;
      #1;
      e = sb.pop_front();
      chk({e.tag, ".num"},    64'(num_retiring),       64'(e.num));
      chk({e.tag, ".req"},    64'(sq_retire_req),      64'(e.req));
      chk({e.tag, ".regs"},   64'(phys_regs_retiring), 64'(e.regs));
      chk({e.tag, ".halted"}, 64'(halt_retired),       64'(e.halted));
      chk({e.tag, ".dead"},   64'(retire_deadlock),    64'(e.dead));
      chk({e.tag, ".count"},  64'(retired_count),      64'(e.cnt));
      @(negedge clock);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      drive(4, 4'hF, 4'h1, 4'h0, 4'hF, 1'b1, 1'b0);
      expect_out(tag, 0, 1'b0, 1'b0, 1'b0);
      compare_next();
      model_cnt = '0;
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vecs.push_back(mkv(4, 4'hF, 4'h0, 4'h0, 4'h5, 1'b0, 4, 1'b0));
      vecs.push_back(mkv(4, 4'hB, 4'h0, 4'h0, 4'h5, 1'b0, 2, 1'b0));
      vecs.push_back(mkv(0, 4'hF, 4'h0, 4'h0, 4'h5, 1'b0, 0, 1'b0));
      vecs.push_back(mkv(2, 4'hF, 4'h0, 4'h0, 4'hA, 1'b0, 2, 1'b0));
      vecs.push_back(mkv(4, 4'hF, 4'h6, 4'h0, 4'h5, 1'b1, 2, 1'b1));
      vecs.push_back(mkv(4, 4'hF, 4'h1, 4'h0, 4'h5, 1'b0, 0, 1'b1));
      vecs.push_back(mkv(4, 4'hF, 4'h1, 4'h0, 4'h5, 1'b1, 1, 1'b1));
      vecs.push_back(mkv(4, 4'hD, 4'h2, 4'h0, 4'h5, 1'b1, 1, 1'b0));
      vecs.push_back(mkv(3, 4'hF, 4'h0, 4'h0, 4'h3, 1'b1, 3, 1'b0));
      vecs.push_back(mkv(4, 4'hE, 4'h0, 4'h0, 4'h5, 1'b0, 0, 1'b0));
      vecs.push_back(mkv(3, 4'hF, 4'h8, 4'h0, 4'hF, 1'b0, 3, 1'b0));
      vecs.push_back(mkv(4, 4'hF, 4'h3, 4'h0, 4'h0, 1'b1, 1, 1'b1));
      vecs.push_back(mkv(4, 4'hF, 4'h1, 4'h2, 4'h5, 1'b1, 1, 1'b1));

      @(negedge clock);
      do_reset("reset_midstore");

      foreach (vecs[k]) begin
         drive(vecs[k].valid, vecs[k].comp, vecs[k].st, vecs[k].hl, vecs[k].dst, vecs[k].ack, 1'b1);
         expect_out($sformatf("vec%0d", k), vecs[k].exp_num, vecs[k].exp_req, 1'b0, 1'b0);
         compare_next();
      end

      for (int c = 0; c < 4; c++) begin
         drive(4, 4'hF, 4'h1, 4'h0, 4'h5, (c == 3), 1'b1);
         expect_out($sformatf("st_wait%0d", c), (c == 3) ? 1 : 0, 1'b1, 1'b0, 1'b0);
         compare_next();
      end

      drive(4, 4'hF, 4'h0, 4'h2, 4'h5, 1'b0, 1'b0);
      expect_out("halt_retire", 2, 1'b0, 1'b0, 1'b0);
      compare_next();
      for (int c = 0; c < 3; c++) begin
         drive(4, 4'hF, 4'h1, 4'h0, 4'h5, 1'b1, (c == 2));
         expect_out($sformatf("drain%0d", c), 0, 1'b0, 1'b0, 1'b0);
         compare_next();
      end
      for (int c = 0; c < 2; c++) begin
         drive(4, 4'hF, 4'h0, 4'h0, 4'h5, 1'b0, 1'b0);
         expect_out($sformatf("halted%0d", c), 0, 1'b0, 1'b1, 1'b0);
         compare_next();
      end
      do_reset("reset_halted");
      drive(4, 4'hF, 4'h0, 4'h0, 4'h6, 1'b0, 1'b1);
      expect_out("after_reset", 4, 1'b0, 1'b0, 1'b0);
      compare_next();

      drive(4, 4'hF, 4'h2, 4'h1, 4'h5, 1'b1, 1'b0);
      expect_out("halt_before_store", 1, 1'b0, 1'b0, 1'b0);
      compare_next();
      drive(4, 4'hF, 4'h1, 4'h0, 4'h5, 1'b1, 1'b0);
      expect_out("drain_blocks_store", 0, 1'b0, 1'b0, 1'b0);
      compare_next();
      do_reset("reset_drain");

      for (int k = 0; k < 10; k++) begin
         drive(4, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 1'b1);
         expect_out($sformatf("stall%0d", k), 0, 1'b0, 1'b0, WD_EN && (k >= int'(WD)));
         compare_next();
      end
      do_reset("reset_stall");
      drive(4, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 1'b1);
      expect_out("stall_after_reset", 0, 1'b0, 1'b0, 1'b0);
      compare_next();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
